// File: rtl/fbus_sram16.sv
// fbus_sram16: F-bus responder fetching 32-bit words as two half-word reads from a 16-bit async SRAM.
// Define FBUS_SRAM16_RANGE_EN to answer fetches outside the top-of-memory window with 32'h0 immediately.
module fbus_sram16 #(
    parameter int AW   = 20,
    parameter int WAIT = 1
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          f_cyc_i,
    input  logic [63:2]   f_adr_i,
    output logic          f_ack_o,
    output logic [31:0]   f_dat_o,
    output logic [AW-1:1] m_adr_o,
    output logic          m_oe_o,
    input  logic [15:0]   m_dat_i
);
    if (WAIT > 15) begin : g_wait_chk
        $error("fbus_sram16: WAIT must be 0..15");
    end
    localparam logic [3:0] W = 4'(WAIT);
    typedef enum logic [1:0] {IDLE, LO, HI, ACK} state_t;
    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:2]   adr_q, adr_d;
    logic [31:0]     dat_q, dat_d;
    logic [AW-1:1]   madr_q, madr_d;
    logic            oe_q, oe_d;
    logic            in_range;
`ifdef FBUS_SRAM16_RANGE_EN
    assign in_range = &f_adr_i[63:AW];
`else
    logic unused_hi;
    assign unused_hi = ^f_adr_i[63:AW];
    assign in_range  = 1'b1;
`endif
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        madr_d  = madr_q;
        oe_d    = oe_q;
        case (state_q)
            IDLE: if (f_cyc_i) begin
                if (!in_range) begin
                    dat_d   = '0;
                    state_d = ACK;
                end else begin
                    adr_d   = f_adr_i[AW-1:2];
                    cnt_d   = W;
                    madr_d  = {f_adr_i[AW-1:2], 1'b0};
                    oe_d    = 1'b1;
                    state_d = LO;
                end
            end
            LO: if (!f_cyc_i) begin
                oe_d    = 1'b0;
                state_d = IDLE;
            end else if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                dat_d[15:0] = m_dat_i;
                madr_d      = {adr_q, 1'b1};
                cnt_d       = W;
                state_d     = HI;
            end
            HI: if (!f_cyc_i) begin
                oe_d    = 1'b0;
                state_d = IDLE;
            end else if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                dat_d[31:16] = m_dat_i;
                oe_d         = 1'b0;
                state_d      = ACK;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            madr_q  <= '0;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            madr_q  <= madr_d;
            oe_q    <= oe_d;
        end
    end
    // An aborted fetch that reaches ACK must stay silent, so ack is gated by the live request.
    assign f_ack_o = (state_q == ACK) & f_cyc_i;
    assign f_dat_o = dat_q;
    assign m_adr_o = madr_q;
    assign m_oe_o  = oe_q;
endmodule

// File: tb/tb_fbus_sram16.sv
// tb_fbus_sram16: scoreboard bench for fbus_sram16 with WAIT=0 and WAIT=3 instances.
module tb_fbus_sram16;
    localparam int AW = 20;
    localparam logic [63:2] RPC  = {44'hFFFFFFFFFFF, 18'h3FC0};
    localparam logic [63:2] LOWA = {44'h0, 18'h3FC0};
    localparam logic [63:2] BASE = {44'hFFFFFFFFFFF, 18'h00100};
    localparam logic [63:2] A2   = {44'hFFFFFFFFFFF, 18'h02000};
    localparam logic [63:2] A3   = {44'hFFFFFFFFFFF, 18'h02345};
    logic clk = 1'b0, rst_n = 1'b0;
    logic cyc0 = 1'b0, cyc3 = 1'b0;
    logic [63:2] adr0 = '0, adr3 = '0;
    logic ack0, ack3, oe0, oe3;
    logic [31:0] dat0, dat3;
    logic [AW-1:1] madr0, madr3;
    logic [15:0] mdat0, mdat3;
    int n_cmp = 0, n_bad = 0;
    logic [31:0] q0[$], q3[$];
    always #5 clk = ~clk;
    function automatic logic [15:0] memf(input logic [AW-1:1] h);
        if (h == 19'h7F80) return 16'h0513;
        if (h == 19'h7F81) return 16'h0000;
        return h[16:1] ^ 16'hA55A;
    endfunction
    function automatic logic [31:0] word_of(input logic [63:2] a);
        logic [AW-1:2] w;
        w = a[AW-1:2];
        return {memf({w, 1'b1}), memf({w, 1'b0})};
    endfunction
    assign mdat0 = memf(madr0);
    assign mdat3 = memf(madr3);
    fbus_sram16 #(.AW(AW), .WAIT(0)) dut0 (
        .clk_i(clk), .reset_ni(rst_n), .f_cyc_i(cyc0), .f_adr_i(adr0), .f_ack_o(ack0),
        .f_dat_o(dat0), .m_adr_o(madr0), .m_oe_o(oe0), .m_dat_i(mdat0));
    fbus_sram16 #(.AW(AW), .WAIT(3)) dut3 (
        .clk_i(clk), .reset_ni(rst_n), .f_cyc_i(cyc3), .f_adr_i(adr3), .f_ack_o(ack3),
        .f_dat_o(dat3), .m_adr_o(madr3), .m_oe_o(oe3), .m_dat_i(mdat3));
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask
    always @(negedge clk) if (ack0) begin
        if (q0.size() == 0) chk("ack0_spurious", 64'(ack0), 64'd0);
        else chk("dat0", 64'(dat0), 64'(q0.pop_front()));
    end
    always @(negedge clk) if (ack3) begin
        if (q3.size() == 0) chk("ack3_spurious", 64'(ack3), 64'd0);
        else chk("dat3", 64'(dat3), 64'(q3.pop_front()));
    end
    // Starts just after a rising edge (or at ack negedge + 1 when chaining); the next negedge is cycle 0.
    task automatic fetch(input bit d, input logic [63:2] a, input int lat, input logic [31:0] exp, input bit keep);
        int w, got;
        w = d ? 3 : 0;
        got = 60;
        if (d) begin q3.push_back(exp); adr3 = a; cyc3 = 1'b1; end
        else begin q0.push_back(exp); adr0 = a; cyc0 = 1'b1; end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (d ? ack3 : ack0) begin
                got = i;
                break;
            end
            if (i >= 1) begin
                chk("m_oe_busy", 64'(d ? oe3 : oe0), 64'd1);
                chk("m_adr", 64'(d ? madr3 : madr0),
                    64'(i <= w + 1 ? {a[AW-1:2], 1'b0} : {a[AW-1:2], 1'b1}));
            end
        end
        chk("latency", 64'(got), 64'(lat));
        chk("m_oe_ack", 64'(d ? oe3 : oe0), 64'd0);
        #1;
        if (!keep) begin cyc0 = 1'b0; cyc3 = 1'b0; end
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", 64'(ack0), 64'd0);
        chk("rst_dat", 64'(dat0), 64'd0);
        chk("rst_madr", 64'(madr0), 64'd0);
        chk("rst_oe", 64'(oe0), 64'd0);
        chk("rst_oe3", 64'(oe3), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        fetch(1'b0, RPC, 3, 32'h0000_0513, 1'b0);
        repeat (2) @(posedge clk); #1;
        fetch(1'b1, RPC, 9, 32'h0000_0513, 1'b1);
        @(negedge clk);
        chk("ack3_width", 64'(ack3), 64'd0);
        #1 cyc3 = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) fetch(1'b0, BASE + 62'(k), 3, word_of(BASE + 62'(k)), k < 7);
        @(posedge clk); #1;
        adr0 = A2; cyc0 = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_hi_adr", 64'(madr0), 64'({A2[AW-1:2], 1'b1}));
        chk("abort_hi_oe", 64'(oe0), 64'd1);
        #1 cyc0 = 1'b0;
        @(negedge clk);
        chk("abort_oe", 64'(oe0), 64'd0);
        chk("abort_ack", 64'(ack0), 64'd0);
        chk("abort_partial", 64'(dat0[15:0]), 64'(memf({A2[AW-1:2], 1'b0})));
        repeat (3) @(negedge clk);
        chk("abort_idle_oe", 64'(oe0), 64'd0);
        @(posedge clk); #1;
        fetch(1'b0, A3, 3, word_of(A3), 1'b0);
        @(posedge clk); #1;
        adr0 = RPC; cyc0 = 1'b1;
        repeat (2) @(negedge clk);
        chk("lo_oe", 64'(oe0), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_oe", 64'(oe0), 64'd0);
        chk("arst_madr", 64'(madr0), 64'd0);
        chk("arst_dat", 64'(dat0), 64'd0);
        chk("arst_ack", 64'(ack0), 64'd0);
        cyc0 = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        fetch(1'b0, RPC, 3, 32'h0000_0513, 1'b0);
        @(posedge clk); #1;
`ifdef FBUS_SRAM16_RANGE_EN
        fetch(1'b0, LOWA, 1, 32'h0000_0000, 1'b0);
`else
        fetch(1'b0, LOWA, 3, 32'h0000_0513, 1'b0);
`endif
        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(q0.size() + q3.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
